// File: rtl/sreg_siso_xfer_ctrl_pkg.sv
// Shared types and helpers for the SISO shift-register transfer controller.
package sreg_siso_xfer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width for a chain of nbits stages.
  function automatic int cnt_width(input int nbits);
    return (nbits < 2) ? 1 : $clog2(nbits);
  endfunction

endpackage

// File: rtl/sreg_siso_xfer_ctrl_dpath.sv
// Datapath: hold register, capture register, bit counter and MSB-first bit mux.
module sreg_siso_xfer_ctrl_dpath #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [NBITS-1:0] load_data,
  input  logic             shift,
  input  logic             sr_sout,
  output logic             sin_bit,
  output logic             last,
  output logic [NBITS-1:0] obuf
);
  import sreg_siso_xfer_ctrl_pkg::*;

  localparam int CNT_W = cnt_width(NBITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBITS - 1);

  logic [NBITS-1:0] hold;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;

  // cnt walks 0..NBITS-1, so idx walks from the MSB down to bit 0.
  assign idx     = CNT_LAST - cnt;
  assign last    = (cnt == CNT_LAST);
  assign sin_bit = hold[idx];

  always_ff @(posedge clk) begin
    if (load) hold <= load_data;
  end

  // obuf samples sout at the same edge that shifts the chain, i.e. the bit
  // leaving the chain before this shift lands in it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      obuf <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (shift) begin
      obuf[idx] <= sr_sout;
      cnt       <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sreg_siso_xfer_ctrl.sv
// Sequencer for an NBITS-deep SISO chain; optional drain via SREG_SISO_XFER_CTRL_FLUSH_EN.
module sreg_siso_xfer_ctrl #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out_data,
  output logic             sr_en,
  output logic             sr_sin,
  input  logic             sr_sout
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
  ,
  input  logic             flush
`endif
);
  import sreg_siso_xfer_ctrl_pkg::*;

  state_t           state;
  logic             en_q;
  logic             flush_go;
  logic             load;
  logic             last;
  logic             sin_bit;
  logic [NBITS-1:0] load_data;

`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
  // in_val wins over flush; a flush pushes an all-zero word through the chain.
  assign flush_go = flush & ~in_val;
`else
  assign flush_go = 1'b0;
`endif

  assign load      = in_rdy & (in_val | flush_go);
  assign load_data = in_val ? in_data : '0;

  // Chain must not shift on the reset edge, so gate the registered enable.
  assign sr_en  = en_q & ~reset;
  assign sr_sin = sr_en & sin_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state  <= SHIFT;
            in_rdy <= 1'b0;
            en_q   <= 1'b1;
          end
        end
        SHIFT: begin
          if (last) begin
            state   <= DONE;
            en_q    <= 1'b0;
            out_val <= 1'b1;
          end
        end
        DONE: begin
          if (out_rdy) begin
            state   <= IDLE;
            out_val <= 1'b0;
            in_rdy  <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          in_rdy  <= 1'b1;
          out_val <= 1'b0;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  sreg_siso_xfer_ctrl_dpath #(
    .NBITS(NBITS)
  ) u_dpath (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .shift    (state == SHIFT),
    .sr_sout  (sr_sout),
    .sin_bit  (sin_bit),
    .last     (last),
    .obuf     (out_data)
  );

endmodule

// File: tb/tb_sreg_siso_xfer_ctrl.sv
// Directed bench for sreg_siso_xfer_ctrl with a behavioural 8-stage SISO chain.
module tb_sreg_siso_xfer_ctrl;
  localparam int NBITS = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_val;
  logic             in_rdy;
  logic [NBITS-1:0] in_data;
  logic             out_val;
  logic             out_rdy;
  logic [NBITS-1:0] out_data;
  logic             sr_en;
  logic             sr_sin;
  logic             sr_sout;
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
  logic             flush;
`endif

  logic [NBITS-1:0] chain;
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Shift-register chain driven by the controller, cleared by the shared reset.
  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else if (sr_en) chain <= {chain[NBITS-2:0], sr_sin};
  end
  assign sr_sout = chain[NBITS-1];

  sreg_siso_xfer_ctrl #(.NBITS(NBITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in_data (in_data),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out_data(out_data),
    .sr_en   (sr_en),
    .sr_sin  (sr_sin),
    .sr_sout (sr_sout)
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
    ,
    .flush   (flush)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One word through the controller: v/fl select in_val/flush, stall holds
  // out_rdy low in DONE, hold_val keeps in_val high with junk data during SHIFT.
  task automatic xfer(input logic v, input logic fl, input logic [7:0] d,
                      input logic [7:0] exp_out, input int stall, input logic hold_val);
    logic [7:0] sins;
    logic [7:0] exp_sin;
    int waited;
    waited = 0;
    while (!in_rdy && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    check("idle_rdy", in_rdy, 1'b1);
    in_val  = v;
    in_data = d;
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
    flush   = fl;
`endif
    out_rdy = (stall == 0);
    @(posedge clk); #1;
    in_val  = hold_val;
    in_data = ~d;
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
    flush   = 1'b0;
`endif
    sins = '0;
    for (int i = 0; i < NBITS; i++) begin
      check("shift_en", sr_en, 1'b1);
      check("shift_rdy", in_rdy, 1'b0);
      check("shift_oval", out_val, 1'b0);
      sins = {sins[6:0], sr_sin};
      @(posedge clk); #1;
    end
    in_val  = 1'b0;
    exp_sin = v ? d : 8'h00;
    if (!v && !fl) exp_sin = 8'h00;
    check("sin_word", sins, exp_sin);
    check("done_en", sr_en, 1'b0);
    check("done_oval", out_val, 1'b1);
    check("done_data", out_data, exp_out);
    check("done_rdy", in_rdy, 1'b0);
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      check("stall_oval", out_val, 1'b1);
      check("stall_data", out_data, exp_out);
      check("stall_rdy", in_rdy, 1'b0);
      check("stall_en", sr_en, 1'b0);
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("back_idle", in_rdy, 1'b1);
    check("back_oval", out_val, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    in_val  = 1'b0;
    in_data = '0;
    out_rdy = 1'b1;
`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
    flush   = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", in_rdy, 1'b1);
    check("rst_oval", out_val, 1'b0);
    check("rst_data", out_data, 8'h00);
    check("rst_en", sr_en, 1'b0);
    check("rst_sin", sr_sin, 1'b0);
    reset = 1'b0;
    @(posedge clk); #1;

    xfer(1'b1, 1'b0, 8'hA5, 8'h00, 0, 1'b0);
    xfer(1'b1, 1'b0, 8'h3C, 8'hA5, 0, 1'b1);
    xfer(1'b1, 1'b0, 8'hFF, 8'h3C, 5, 1'b0);

    // Reset in the 5th SHIFT cycle of 0x81 abandons the word and clears the chain.
    in_val  = 1'b1;
    in_data = 8'h81;
    @(posedge clk); #1;
    in_val = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_en_pre", sr_en, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_en", sr_en, 1'b0);
    check("mid_rst_sin", sr_sin, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rdy", in_rdy, 1'b1);
    check("mid_oval", out_val, 1'b0);
    check("mid_data", out_data, 8'h00);
    xfer(1'b1, 1'b0, 8'h12, 8'h00, 0, 1'b0);

`ifdef SREG_SISO_XFER_CTRL_FLUSH_EN
    xfer(1'b1, 1'b0, 8'h5A, 8'h12, 0, 1'b0);
    xfer(1'b0, 1'b1, 8'h99, 8'h5A, 0, 1'b0);
    xfer(1'b1, 1'b0, 8'h01, 8'h00, 0, 1'b0);
    xfer(1'b1, 1'b1, 8'h66, 8'h01, 0, 1'b0);
    xfer(1'b1, 1'b0, 8'h00, 8'h66, 0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
